// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants for the VGA timing generator and its helpers.
package vga_pkg;

  localparam int COUNT_W = 10;
  localparam int PIX_DIV = 4;

  typedef logic [COUNT_W-1:0] count_t;

  // Horizontal timing, in pixel slots
  localparam count_t H_TOTAL     = 10'd800;
  localparam count_t H_SYNC      = 10'd96;
  localparam count_t H_VIS_START = 10'd144;
  localparam count_t H_VIS_END   = 10'd783;

  // Vertical timing, in lines
  localparam count_t V_TOTAL     = 10'd525;
  localparam count_t V_SYNC      = 10'd2;
  localparam count_t V_VIS_START = 10'd35;
  localparam count_t V_VIS_END   = 10'd514;

  // Last legal value of each axis; anything at or above it returns to zero
  localparam count_t H_LAST = H_TOTAL - 10'd1;
  localparam count_t V_LAST = V_TOTAL - 10'd1;

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the raster: counts inc pulses 0..wrap_at, then returns to 0.
// Values above wrap_at (unreachable in normal operation) also return to 0 on
// the next inc, but only a wrap from exactly wrap_at is reported on wrap.
module vga_axis_counter
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic [COUNT_W-1:0] wrap_at,
  output logic [COUNT_W-1:0] count,
  output logic               wrap
);

  count_t count_reg;
  count_t count_next;

  // Next count: hold, step, or return to zero at/after the last value
  always_comb begin
    count_next = count_reg;
    if (inc) begin
      if (count_reg >= wrap_at) begin
        count_next = '0;
      end else begin
        count_next = count_reg + count_t'(1);
      end
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign wrap  = inc && (count_reg == wrap_at);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA 640x480 timing generator: 100 MHz clk divided by 4 into pixel slots,
// horizontal/vertical raster counters, and registered sync/bright/frame decodes.
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COUNT_W-1:0] hCount,
  output logic [COUNT_W-1:0] vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic               frame_tick
);

  localparam int DIV_W = $clog2(PIX_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic             h_wrap;
  logic             v_wrap;
  count_t           h_count;
  count_t           v_count;

  logic h_sync_reg;
  logic v_sync_reg;
  logic bright_reg;
  logic frame_tick_reg;
  logic h_sync_next;
  logic v_sync_next;
  logic bright_next;

  // Free-running pixel-slot divider; wraps naturally at its width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  assign pix_en = (div_reg == DIV_LAST);

  vga_axis_counter u_h_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (pix_en),
    .wrap_at (H_LAST),
    .count   (h_count),
    .wrap    (h_wrap)
  );

  // Lines advance only when the horizontal counter leaves its last pixel
  vga_axis_counter u_v_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (h_wrap),
    .wrap_at (V_LAST),
    .count   (v_count),
    .wrap    (v_wrap)
  );

  // Decode of the current counts; registered below so it trails the counts by one clk
  always_comb begin
    h_sync_next = (h_count >= H_SYNC);
    v_sync_next = (v_count >= V_SYNC);
    bright_next = (h_count >= H_VIS_START) && (h_count <= H_VIS_END) &&
                  (v_count >= V_VIS_START) && (v_count <= V_VIS_END);
  end

  // Sync/bright registers and the end-of-frame pulse (lands as both counts hit 0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_sync_reg     <= 1'b0;
      v_sync_reg     <= 1'b0;
      bright_reg     <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      h_sync_reg     <= h_sync_next;
      v_sync_reg     <= v_sync_next;
      bright_reg     <= bright_next;
      frame_tick_reg <= v_wrap;
    end
  end

  assign hCount     = h_count;
  assign vCount     = v_count;
  assign hSync      = h_sync_reg;
  assign vSync      = v_sync_reg;
  assign bright     = bright_reg;
  assign frame_tick = frame_tick_reg;

endmodule
